dmem_latency_model: RTL and testbench

Synthesizable, parametrised data-memory responder for the core's data bus (MREQ/WRITE/SIZE/DAD, active-low ACKD_n). It emulates a word-organised memory with programmable access latency, word/half/byte lane steering and memory-mapped stdout/exit ports. It replaces behavioural bench memory so the same model runs in simulation and on FPGA, and adds range and alignment error reporting.

---
 rtl/dmem_latency_model_if.sv | 22 ++
 rtl/dmem_latency_model.sv | 197 +++++++++++++++++++
 tb/tb_dmem_latency_model.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_latency_model_if.sv
// Core data-bus bundle: request side driven by the core, completion side by memory.
// ACKD_n is an active-low single-cycle completion strobe; err and rdata are valid with it.
interface dmem_latency_model_if;
   logic        MREQ;
   logic        WRITE;
   logic [1:0]  SIZE;
   logic [31:0] DAD;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ACKD_n;
   logic        err;

   modport master (
      output MREQ, WRITE, SIZE, DAD, wdata,
      input  rdata, ACKD_n, err
   );

   modport slave (
      input  MREQ, WRITE, SIZE, DAD, wdata,
      output rdata, ACKD_n, err
   );
endinterface

// File: rtl/dmem_latency_model.sv
// Word-organised data memory with programmable ack latency, byte/half lane steering,
// range/alignment error reporting and memory-mapped stdout/exit ports.
module dmem_latency_model #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] STDOUT_ADDR = 32'hf000_0000,
   parameter logic [31:0] EXIT_ADDR   = 32'hff00_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   dmem_latency_model_if.slave  bus,
   output logic                 stdout_valid,
   output logic [7:0]           stdout_char,
   output logic                 exit_req
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        capture;
   logic        enter_ack;

   logic [31:0] addr_reg;
   logic        we_reg;
   logic [1:0]  size_reg;
   logic [31:0] wdata_reg;

   logic [31:0] req_addr;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;

   logic [32:0]   off_full;
   logic [AW-1:0] word_idx;
   logic          in_range;
   logic          is_byte, is_half, is_word;
   logic          misaligned;
   logic          is_stdout, is_exit;
   logic          req_err;
   logic          mem_ok;
   logic          mem_write;
   logic [3:0]    be;
   logic [3:0]    lane_we;
   logic [31:0]   wword;
   logic [31:0]   rword;
   logic [31:0]   load_val;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_reg;
   logic        err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // A new request may be taken in IDLE or on the edge leaving ACK (back-to-back).
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      case (state_reg)
         IDLE, ACK: begin
            if (bus.MREQ) begin
               capture = 1'b1;
               if (LATENCY == 1) begin
                  state_next = ACK;
               end else begin
                  state_next = WAIT;
                  cnt_next   = WAIT_INIT;
               end
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd1) state_next = ACK;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         default: state_next = IDLE;
      endcase
      enter_ack = (state_next == ACK) && !rst;
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         addr_reg  <= bus.DAD;
         we_reg    <= bus.WRITE;
         size_reg  <= bus.SIZE;
         wdata_reg <= bus.wdata;
      end
   end

   // Outside WAIT the request entering ACK is the one on the bus this very edge (LATENCY==1).
   always_comb begin
      req_addr  = (state_reg == WAIT) ? addr_reg  : bus.DAD;
      req_we    = (state_reg == WAIT) ? we_reg    : bus.WRITE;
      req_size  = (state_reg == WAIT) ? size_reg  : bus.SIZE;
      req_wdata = (state_reg == WAIT) ? wdata_reg : bus.wdata;
   end

   always_comb begin
      off_full   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
      in_range   = off_full < MEM_BYTES;
      word_idx   = off_full[AW+1:2];
      is_byte    = req_size[1];
      is_half    = (req_size == 2'b01);
      is_word    = (req_size == 2'b00);
      misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
      is_stdout  = (req_addr == STDOUT_ADDR);
      is_exit    = (req_addr == EXIT_ADDR);
      mem_ok     = !is_stdout && !is_exit && in_range && !misaligned;
      if (is_stdout)    req_err = req_we && !is_byte;
      else if (is_exit) req_err = 1'b0;
      else              req_err = !in_range || misaligned;
      mem_write  = enter_ack && req_we && mem_ok;
   end

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be    = 4'b1111;
      wword = req_wdata;
      if (is_byte) begin
         be    = 4'b0001 << req_addr[1:0];
         wword = {4{req_wdata[7:0]}};
      end else if (is_half) begin
         be    = req_addr[1] ? 4'b1100 : 4'b0011;
         wword = {2{req_wdata[15:0]}};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane_we
         assign lane_we[gi] = mem_write && be[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (lane_we[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
   end

   assign rword = mem[word_idx];

   always_comb begin
      load_val = rword;
      if (is_byte) begin
         case (req_addr[1:0])
            2'b00:   load_val = {24'd0, rword[7:0]};
            2'b01:   load_val = {24'd0, rword[15:8]};
            2'b10:   load_val = {24'd0, rword[23:16]};
            default: load_val = {24'd0, rword[31:24]};
         endcase
      end else if (is_half) begin
         load_val = req_addr[1] ? {16'd0, rword[31:16]} : {16'd0, rword[15:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg    <= 32'd0;
         err_reg      <= 1'b0;
         stdout_valid <= 1'b0;
         stdout_char  <= 8'd0;
         exit_req     <= 1'b0;
      end else begin
         stdout_valid <= 1'b0;
         if (enter_ack) begin
            err_reg <= req_err;
            if (!req_we) rdata_reg <= mem_ok ? load_val : 32'd0;
            if (req_we && is_stdout && is_byte) begin
               stdout_valid <= 1'b1;
               stdout_char  <= req_wdata[7:0];
            end
            if (req_we && is_exit) exit_req <= 1'b1;
         end
      end
   end

   assign bus.ACKD_n = (state_reg != ACK);
   assign bus.rdata  = rdata_reg;
   assign bus.err    = err_reg;

endmodule

// File: tb/tb_dmem_latency_model.sv
// Directed bench for dmem_latency_model: three instances at latencies 1, 4 and 3.
module tb_dmem_latency_model;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   dmem_latency_model_if b1();
   dmem_latency_model_if b4();
   dmem_latency_model_if b3();

   logic       sv1, sv4, sv3;
   logic [7:0] sc1, sc4, sc3;
   logic       ex1, ex4, ex3;

   dmem_latency_model #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1),
      .stdout_valid(sv1), .stdout_char(sc1), .exit_req(ex1));
   dmem_latency_model #(.LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(b4),
      .stdout_valid(sv4), .stdout_char(sc4), .exit_req(ex4));
   dmem_latency_model #(.LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(b3),
      .stdout_valid(sv3), .stdout_char(sc3), .exit_req(ex3));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Single LATENCY=1 transaction; samples the ack cycle and the cycle after it.
   task automatic xact1(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        output logic ackn1, output logic ackn2, output logic [31:0] rd, output logic er,
                        output logic sv, output logic [7:0] sc, output logic sv_after);
      @(negedge clk);
      b1.MREQ = 1'b1; b1.WRITE = we; b1.SIZE = sz; b1.DAD = a; b1.wdata = d;
      @(negedge clk);
      ackn1 = b1.ACKD_n; rd = b1.rdata; er = b1.err; sv = sv1; sc = sc1;
      b1.MREQ = 1'b0;
      @(negedge clk);
      ackn2 = b1.ACKD_n; sv_after = sv1;
      $display("xact L1 we=%0b size=%b addr=%h wdata=%h -> ackn=%b,%b rdata=%h err=%b", we, sz, a, d, ackn1, ackn2, rd, er);
   endtask

   task automatic run4(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      b4.MREQ = 1'b1; b4.WRITE = we; b4.SIZE = sz; b4.DAD = a; b4.wdata = d;
      @(negedge clk);
      b4.MREQ = 1'b0;
      lat = 1;
      while (b4.ACKD_n && lat < 20) begin @(negedge clk); lat++; end
      if (b4.ACKD_n) lat = -1;
      rd = b4.rdata; er = b4.err;
      @(negedge clk);
      $display("xact L4 we=%0b addr=%h wdata=%h -> lat=%0d rdata=%h err=%b", we, a, d, lat, rd, er);
   endtask

   task automatic run3(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      b3.MREQ = 1'b1; b3.WRITE = we; b3.SIZE = sz; b3.DAD = a; b3.wdata = d;
      @(negedge clk);
      b3.MREQ = 1'b0;
      lat = 1;
      while (b3.ACKD_n && lat < 20) begin @(negedge clk); lat++; end
      if (b3.ACKD_n) lat = -1;
      rd = b3.rdata; er = b3.err;
      @(negedge clk);
      $display("xact L3 we=%0b addr=%h wdata=%h -> lat=%0d rdata=%h err=%b", we, a, d, lat, rd, er);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      b1.MREQ = 1'b0; b4.MREQ = 1'b0; b3.MREQ = 1'b0;
      b1.WRITE = 1'b0; b4.WRITE = 1'b0; b3.WRITE = 1'b0;
      b1.SIZE = 2'b00; b4.SIZE = 2'b00; b3.SIZE = 2'b00;
      b1.DAD = '0; b4.DAD = '0; b3.DAD = '0;
      b1.wdata = '0; b4.wdata = '0; b3.wdata = '0;
      repeat (2) @(negedge clk);
      vectors++; if (b1.ACKD_n !== 1'b1) begin miscompares++; $display("FAIL reset_ackn: got %b want 1", b1.ACKD_n); end
      vectors++; if (b1.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", b1.err); end
      vectors++; if (b1.rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", b1.rdata); end
      vectors++; if (sv1 !== 1'b0 || sc1 !== 8'd0) begin miscompares++; $display("FAIL reset_stdout: got %b/%h want 0/00", sv1, sc1); end
      vectors++; if (ex1 !== 1'b0) begin miscompares++; $display("FAIL reset_exit: got %b want 0", ex1); end
      vectors++; if (b4.ACKD_n !== 1'b1 || b3.ACKD_n !== 1'b1) begin miscompares++; $display("FAIL reset_ackn_l4l3: got %b/%b want 1/1", b4.ACKD_n, b3.ACKD_n); end
      rst = 1'b0;
   endtask

   task automatic test_word();
      logic a1, a2, er, sv, sva; logic [31:0] rd; logic [7:0] sc;
      xact1(1'b1, 2'b00, 32'h0800_0000, 32'h1122_3344, a1, a2, rd, er, sv, sc, sva);
      vectors++; if ({a1, a2} !== 2'b01) begin miscompares++; $display("FAIL word_store_ack: got %b%b want 01", a1, a2); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL word_store_err: got %b want 0", er); end
      xact1(1'b0, 2'b00, 32'h0800_0000, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if ({a1, a2} !== 2'b01) begin miscompares++; $display("FAIL word_load_ack: got %b%b want 01", a1, a2); end
      vectors++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin miscompares++; $display("FAIL word_load: got %h err %b want 11223344 err 0", rd, er); end
   endtask

   task automatic test_lanes();
      logic a1, a2, er, sv, sva; logic [31:0] rd; logic [7:0] sc;
      logic [31:0] offs [6];
      logic [1:0]  szs  [6];
      logic [31:0] exps [6];
      offs = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd2};
      szs  = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01};
      exps = '{32'h0000_00DD, 32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA, 32'h0000_CCDD, 32'h0000_AABB};
      xact1(1'b1, 2'b00, 32'h0800_0010, 32'hAABB_CCDD, a1, a2, rd, er, sv, sc, sva);
      for (int i = 0; i < 6; i++) begin
         xact1(1'b0, szs[i], 32'h0800_0010 + offs[i], 32'h0, a1, a2, rd, er, sv, sc, sva);
         vectors++; if (rd !== exps[i] || er !== 1'b0) begin miscompares++; $display("FAIL lane_load_%0d: got %h err %b want %h err 0", i, rd, er, exps[i]); end
      end
      xact1(1'b1, 2'b10, 32'h0800_0011, 32'h1234_565A, a1, a2, rd, er, sv, sc, sva);
      xact1(1'b0, 2'b00, 32'h0800_0010, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (rd !== 32'hAABB_5ADD) begin miscompares++; $display("FAIL byte_store_merge: got %h want aabb5add", rd); end
   endtask

   task automatic test_errors();
      logic a1, a2, er, sv, sva; logic [31:0] rd; logic [7:0] sc;
      xact1(1'b0, 2'b01, 32'h0800_0001, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (a1 !== 1'b0 || er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL half_misaligned: got ackn %b err %b rdata %h want 0/1/0", a1, er, rd); end
      xact1(1'b0, 2'b00, 32'h0800_1000, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (a1 !== 1'b0 || er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL word_out_of_range: got ackn %b err %b rdata %h want 0/1/0", a1, er, rd); end
      xact1(1'b1, 2'b00, 32'h0800_0FFC, 32'h0F0F_0F0F, a1, a2, rd, er, sv, sc, sva);
      xact1(1'b0, 2'b00, 32'h0800_0FFC, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (rd !== 32'h0F0F_0F0F || er !== 1'b0) begin miscompares++; $display("FAIL last_word: got %h err %b want 0f0f0f0f err 0", rd, er); end
      xact1(1'b0, 2'b00, 32'h07FF_FFFC, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (er !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL below_base: got err %b rdata %h want 1/0", er, rd); end
      xact1(1'b0, 2'b00, 32'h0800_0002, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL word_misaligned: got err %b want 1", er); end
      xact1(1'b1, 2'b00, 32'h0800_0012, 32'hDEAD_BEEF, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL bad_store_err: got err %b want 1", er); end
      xact1(1'b0, 2'b00, 32'h0800_0010, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (rd !== 32'hAABB_5ADD) begin miscompares++; $display("FAIL bad_store_kept: got %h want aabb5add", rd); end
      xact1(1'b1, 2'b00, 32'h0800_1000, 32'hDEAD_BEEF, a1, a2, rd, er, sv, sc, sva);
      xact1(1'b0, 2'b00, 32'h0800_0000, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (rd !== 32'h1122_3344) begin miscompares++; $display("FAIL range_store_kept: got %h want 11223344", rd); end
   endtask

   task automatic test_mmio();
      logic a1, a2, er, sv, sva; logic [31:0] rd; logic [7:0] sc;
      xact1(1'b1, 2'b10, 32'hF000_0000, 32'h1234_5641, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (sv !== 1'b1 || sc !== 8'h41 || er !== 1'b0) begin miscompares++; $display("FAIL stdout_char: got valid %b char %h err %b want 1/41/0", sv, sc, er); end
      vectors++; if (sva !== 1'b0) begin miscompares++; $display("FAIL stdout_pulse: got valid %b after ack want 0", sva); end
      xact1(1'b1, 2'b00, 32'hF000_0000, 32'h0000_0042, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (er !== 1'b1 || sv !== 1'b0) begin miscompares++; $display("FAIL stdout_word: got err %b valid %b want 1/0", er, sv); end
      xact1(1'b0, 2'b10, 32'hF000_0000, 32'h0, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (rd !== 32'd0 || er !== 1'b0) begin miscompares++; $display("FAIL stdout_load: got %h err %b want 0/0", rd, er); end
      vectors++; if (ex1 !== 1'b0) begin miscompares++; $display("FAIL exit_pre: got %b want 0", ex1); end
      xact1(1'b1, 2'b00, 32'hFF00_0000, 32'h0000_0001, a1, a2, rd, er, sv, sc, sva);
      vectors++; if (ex1 !== 1'b1 || er !== 1'b0) begin miscompares++; $display("FAIL exit_set: got exit %b err %b want 1/0", ex1, er); end
      repeat (3) @(negedge clk);
      vectors++; if (ex1 !== 1'b1) begin miscompares++; $display("FAIL exit_sticky: got %b want 1", ex1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int lat;
      logic exp_n;
      run4(1'b1, 2'b00, 32'h0800_0000, 32'hCAFE_0001, rd, er, lat);
      vectors++; if (lat != 4) begin miscompares++; $display("FAIL l4_store_latency: got %0d want 4", lat); end
      run4(1'b1, 2'b00, 32'h0800_0004, 32'h0000_BEEF, rd, er, lat);
      @(negedge clk);
      b4.MREQ = 1'b1; b4.WRITE = 1'b0; b4.SIZE = 2'b00; b4.DAD = 32'h0800_0000;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         exp_n = (c == 4 || c == 8) ? 1'b0 : 1'b1;
         vectors++; if (b4.ACKD_n !== exp_n) begin miscompares++; $display("FAIL b2b_ack_cycle_%0d: got %b want %b", c, b4.ACKD_n, exp_n); end
         if (c == 4) begin
            vectors++; if (b4.rdata !== 32'hCAFE_0001) begin miscompares++; $display("FAIL b2b_first: got %h want cafe0001", b4.rdata); end
            b4.DAD = 32'h0800_0004;
         end
         if (c == 5) b4.MREQ = 1'b0;
         if (c == 8) begin
            vectors++; if (b4.rdata !== 32'h0000_BEEF) begin miscompares++; $display("FAIL b2b_second: got %h want 0000beef", b4.rdata); end
         end
      end
      $display("xact L4 back-to-back loads 08000000,08000004 done");
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] rd; logic er; int lat;
      run3(1'b1, 2'b00, 32'h0800_0020, 32'h1234_5678, rd, er, lat);
      vectors++; if (lat != 3) begin miscompares++; $display("FAIL l3_store_latency: got %0d want 3", lat); end
      @(negedge clk);
      b3.MREQ = 1'b1; b3.WRITE = 1'b1; b3.SIZE = 2'b00; b3.DAD = 32'h0800_0020; b3.wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      b3.MREQ = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (b3.ACKD_n !== 1'b1 || b3.err !== 1'b0 || b3.rdata !== 32'd0) begin miscompares++; $display("FAIL rst_wait_outputs: got ackn %b err %b rdata %h want 1/0/0", b3.ACKD_n, b3.err, b3.rdata); end
      vectors++; if (ex1 !== 1'b0 || sc1 !== 8'd0 || b1.rdata !== 32'd0) begin miscompares++; $display("FAIL rst_clears: got exit %b char %h rdata %h want 0/00/0", ex1, sc1, b1.rdata); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++; if (b3.ACKD_n !== 1'b1) begin miscompares++; $display("FAIL rst_no_ack_%0d: got %b want 1", c, b3.ACKD_n); end
      end
      run3(1'b0, 2'b00, 32'h0800_0020, 32'h0, rd, er, lat);
      vectors++; if (rd !== 32'h1234_5678 || lat != 3) begin miscompares++; $display("FAIL rst_store_dropped: got %h lat %0d want 12345678 lat 3", rd, lat); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_lanes();
      test_errors();
      test_mmio();
      test_back_to_back();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
